// File: rtl/loop_nest_counter.sv
// loop_nest_counter
//   N-dimension nested loop counter. Dimension 0 is innermost and steps on
//   each accepted advance. It carries into the outer dimensions and produces
//   tile/row/column indices for the address generators. The per-dimension
//   inclusive end values are latched on clear, so the control FSM may change
//   endValsIn while a run is in progress.
//
// Parameters
//   NUM_DIMS   number of nested dimensions (>= 1), dim 0 innermost
//   CNT_WIDTH  width of each dimension's counter and end value
//
// Ports
//   clkIn      clock, all state updates on the rising edge
//   rstNIn     asynchronous active-low reset
//   clrIn      synchronous clear: zero counters, latch endValsIn
//   advIn      advance request (step dim 0)
//   endValsIn  inclusive end value per dim, dim d at [d*CNT_WIDTH +: CNT_WIDTH]
//   cntsOut    current index per dim, same packing
//   wrapOut    1-cycle pulse per dim: dim rolled over from its end to 0
//   advAckOut  1-cycle pulse: advance accepted
//   doneOut    every dim at its end value (final iteration reached)
//
// Build option
//   LOOP_NEST_COUNTER_AUTOWRAP_EN: when defined, an advance while done
//   restarts the same nest (counters to 0, all wrap bits pulse). When it is
//   undefined, the counter saturates at done and ignores advances.

module loop_nest_counter #(
  parameter int unsigned NUM_DIMS  = 3,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                          clkIn,
  input  logic                          rstNIn,
  input  logic                          clrIn,
  input  logic                          advIn,
  input  logic [NUM_DIMS*CNT_WIDTH-1:0] endValsIn,
  output logic [NUM_DIMS*CNT_WIDTH-1:0] cntsOut,
  output logic [NUM_DIMS-1:0]           wrapOut,
  output logic                          advAckOut,
  output logic                          doneOut
);

  logic [NUM_DIMS*CNT_WIDTH-1:0] cntR;
  logic [NUM_DIMS*CNT_WIDTH-1:0] endR;
  logic [NUM_DIMS*CNT_WIDTH-1:0] cntNext;
  logic [NUM_DIMS-1:0]           wrapR;
  logic [NUM_DIMS-1:0]           wrapNext;
  logic [NUM_DIMS-1:0]           atEnd;
  logic                          ackR;
  logic                          ackNext;
  logic                          doneR;
  logic                          doneNext;
  logic                          allAtEnd;

  // Per-dimension "at end" flags for the current counter state.
  always_comb begin
    atEnd    = '0;
    allAtEnd = 1'b1;
    for (int unsigned d = 0; d < NUM_DIMS; d++) begin
      atEnd[d] = (cntR[d*CNT_WIDTH +: CNT_WIDTH] == endR[d*CNT_WIDTH +: CNT_WIDTH]);
      allAtEnd = allAtEnd & atEnd[d];
    end
  end

  // Next-state logic. The carry walks outward from dim 0 and stays set only
  // while every lower dim sits at its end. The first dim that is not at its
  // end takes the increment and kills the carry. Lower dims are cleared only
  // when some outer dim actually increments, so when nothing can move the
  // counter holds. An end of 0 clears a dim that is already 0, and that dim
  // never reports a wrap.
  always_comb begin
    logic carry;
    logic doneCalc;
    cntNext  = cntR;
    wrapNext = '0;
    ackNext  = 1'b0;
    doneNext = doneR;
    carry    = 1'b1;
    doneCalc = 1'b1;

    if (clrIn) begin
      cntNext  = '0;
      doneNext = (endValsIn == '0);
    end else if (advIn && !doneR) begin
      ackNext = 1'b1;
      for (int unsigned d = 0; d < NUM_DIMS; d++) begin
        if (carry) begin
          if (!atEnd[d]) begin
            cntNext[d*CNT_WIDTH +: CNT_WIDTH] =
              cntR[d*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
          end else if (!allAtEnd) begin
            cntNext[d*CNT_WIDTH +: CNT_WIDTH] = '0;
            wrapNext[d] = (endR[d*CNT_WIDTH +: CNT_WIDTH] != '0);
          end
        end
        carry = carry & atEnd[d];
      end
      for (int unsigned d = 0; d < NUM_DIMS; d++) begin
        doneCalc = doneCalc &
          (cntNext[d*CNT_WIDTH +: CNT_WIDTH] == endR[d*CNT_WIDTH +: CNT_WIDTH]);
      end
      doneNext = doneCalc;
`ifdef LOOP_NEST_COUNTER_AUTOWRAP_EN
    end else if (advIn) begin
      // Restart the same nest. When every end is 0 the nest has a single
      // iteration, so the counter stays done and nothing wraps.
      ackNext = 1'b1;
      if (endR == '0) begin
        doneNext = 1'b1;
      end else begin
        cntNext  = '0;
        wrapNext = '1;
        doneNext = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      cntR  <= '0;
      endR  <= '0;
      wrapR <= '0;
      ackR  <= 1'b0;
      doneR <= 1'b0;
    end else begin
      cntR  <= cntNext;
      wrapR <= wrapNext;
      ackR  <= ackNext;
      doneR <= doneNext;
      if (clrIn) begin
        endR <= endValsIn;
      end
    end
  end

  assign cntsOut   = cntR;
  assign wrapOut   = wrapR;
  assign advAckOut = ackR;
  assign doneOut   = doneR;

endmodule

// File: tb/tb_loop_nest_counter.sv
// tb_loop_nest_counter
//   Self-checking bench for loop_nest_counter. The main instance uses
//   NUM_DIMS=3 and CNT_WIDTH=8. A second instance uses NUM_DIMS=1 and
//   CNT_WIDTH=4. The reference model tracks a linear iteration index and
//   derives each dimension's index as a mixed-radix digit of it. The same
//   bench covers both values of LOOP_NEST_COUNTER_AUTOWRAP_EN.

module tb_loop_nest_counter;

  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rstN;
  logic           clr;
  logic           adv;
  logic [N*W-1:0] endVals;
  logic [N*W-1:0] cnts;
  logic [N-1:0]   wrap;
  logic           ack;
  logic           done;

  logic           clr1;
  logic           adv1;
  logic [3:0]     end1;
  logic [3:0]     cnts1;
  logic [0:0]     wrap1;
  logic           ack1;
  logic           done1;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;
  bit sawWrap1 = 1'b0;

  loop_nest_counter #(.NUM_DIMS(N), .CNT_WIDTH(W)) dut (
    .clkIn(clk), .rstNIn(rstN), .clrIn(clr), .advIn(adv),
    .endValsIn(endVals), .cntsOut(cnts), .wrapOut(wrap),
    .advAckOut(ack), .doneOut(done)
  );

  loop_nest_counter #(.NUM_DIMS(1), .CNT_WIDTH(4)) dut1 (
    .clkIn(clk), .rstNIn(rstN), .clrIn(clr1), .advIn(adv1),
    .endValsIn(end1), .cntsOut(cnts1), .wrapOut(wrap1),
    .advAckOut(ack1), .doneOut(done1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       mEnd [N];
  int       mIdx;
  logic [N-1:0] mWrap;
  bit       mAck;
  bit       mDone;

  function automatic int total();
    int t = 1;
    for (int d = 0; d < N; d++) t = t * (mEnd[d] + 1);
    return t;
  endfunction

  function automatic int digit(input int idx, input int d);
    int div = 1;
    for (int j = 0; j < d; j++) div = div * (mEnd[j] + 1);
    return (idx / div) % (mEnd[d] + 1);
  endfunction

  function automatic logic [N*W-1:0] expCnts();
    logic [N*W-1:0] v = '0;
    for (int d = 0; d < N; d++) v[d*W +: W] = W'(digit(mIdx, d));
    return v;
  endfunction

  function automatic logic [N-1:0] stepWrap(input int oldIdx);
    logic [N-1:0] w = '0;
    for (int d = 0; d < N; d++)
      w[d] = (mEnd[d] != 0) && (digit(oldIdx, d) == mEnd[d]) && (digit(oldIdx + 1, d) == 0);
    return w;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int d = 0; d < N; d++) mEnd[d] <= 0;
      mIdx  <= 0;
      mWrap <= '0;
      mAck  <= 1'b0;
      mDone <= 1'b0;
    end else if (clr) begin
      for (int d = 0; d < N; d++) mEnd[d] <= int'(endVals[d*W +: W]);
      mIdx  <= 0;
      mWrap <= '0;
      mAck  <= 1'b0;
      mDone <= (endVals == '0);
    end else if (adv && !mDone) begin
      mAck <= 1'b1;
      if (mIdx < total() - 1) begin
        mIdx  <= mIdx + 1;
        mWrap <= stepWrap(mIdx);
        mDone <= (mIdx + 1 == total() - 1);
      end else begin
        mWrap <= '0;
        mDone <= 1'b1;
      end
`ifdef LOOP_NEST_COUNTER_AUTOWRAP_EN
    end else if (adv) begin
      mAck <= 1'b1;
      if (total() == 1) begin
        mWrap <= '0;
        mDone <= 1'b1;
      end else begin
        mIdx  <= 0;
        mWrap <= '1;
        mDone <= 1'b0;
      end
`endif
    end else begin
      mAck  <= 1'b0;
      mWrap <= '0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_cnts", 64'(cnts), 64'(expCnts()));
      chk("model_wrap", 64'(wrap), 64'(mWrap));
      chk("model_ack",  64'(ack),  64'(mAck));
      chk("model_done", 64'(done), 64'(mDone));
      if (wrap[1]) sawWrap1 = 1'b1;
    end
  end

  task automatic cyc(input logic a, input logic c);
    adv = a;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic advN(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rstN    = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    endVals = '0;
    clr1    = 1'b0;
    adv1    = 1'b0;
    end1    = '0;
    #1 armed = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_cnts", 64'(cnts), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ack",  64'(ack),  64'h0);
    rstN = 1'b1;
    cyc(1'b0, 1'b0);
    chk("rst_done_noclr", 64'(done), 64'h0);

    // ends (1,2,3): 24 iterations
    endVals = 24'h030201;
    cyc(1'b0, 1'b1);
    chk("clr_done", 64'(done), 64'h0);
    advN(2);
    chk("adv2_cnts", 64'(cnts), 64'h000100);
    chk("adv2_wrap", 64'(wrap), 64'h1);
    chk("adv2_ack",  64'(ack),  64'h1);
    advN(4);
    chk("adv6_cnts", 64'(cnts), 64'h010000);
    chk("adv6_wrap", 64'(wrap), 64'h3);
    advN(16);
    chk("adv22_done", 64'(done), 64'h0);
    advN(1);
    chk("adv23_done", 64'(done), 64'h1);
    chk("adv23_cnts", 64'(cnts), 64'h030201);
    chk("adv23_wrap", 64'(wrap), 64'h0);
    chk("model_idx23", 64'(mIdx), 64'd23);
    advN(1);
`ifdef LOOP_NEST_COUNTER_AUTOWRAP_EN
    chk("adv24_ack",  64'(ack),  64'h1);
    chk("adv24_cnts", 64'(cnts), 64'h0);
`else
    chk("adv24_ack",  64'(ack),  64'h0);
    chk("adv24_cnts", 64'(cnts), 64'h030201);
`endif
    cyc(1'b0, 1'b0);
    chk("idle_ack", 64'(ack), 64'h0);

    // all-zero ends
    endVals = '0;
    cyc(1'b0, 1'b1);
    chk("zero_done", 64'(done), 64'h1);
    advN(1);
`ifdef LOOP_NEST_COUNTER_AUTOWRAP_EN
    chk("zero_ack", 64'(ack), 64'h1);
`else
    chk("zero_ack", 64'(ack), 64'h0);
`endif
    chk("zero_done2", 64'(done), 64'h1);
    chk("zero_wrap",  64'(wrap), 64'h0);

    // ends (2,0,1): dim 1 transparent
    endVals = 24'h010002;
    cyc(1'b0, 1'b1);
    sawWrap1 = 1'b0;
    advN(5);
    chk("e201_done", 64'(done), 64'h1);
    chk("e201_cnts", 64'(cnts), 64'h010002);
    chk("e201_nowrap1", 64'(sawWrap1), 64'h0);
    cyc(1'b1, 1'b1);
    chk("clradv_cnts", 64'(cnts), 64'h0);
    chk("clradv_ack",  64'(ack),  64'h0);
    chk("clradv_done", 64'(done), 64'h0);

    // latched ends ignore endValsIn changes; mid-run reset
    endVals = 24'h030201;
    cyc(1'b0, 1'b1);
    advN(3);
    chk("mid_cnts", 64'(cnts), 64'h000101);
    endVals = 24'h050505;
    advN(1);
    chk("latched_cnts", 64'(cnts), 64'h000200);
    advN(2);
    chk("latched_cnts2", 64'(cnts), 64'h010000);
    rstN = 1'b0;
    #2;
    chk("midrst_cnts", 64'(cnts), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    cyc(1'b0, 1'b0);
    rstN = 1'b1;
    cyc(1'b0, 1'b0);

    // ends (1,1,1): restart behaviour on the 8th advance
    endVals = 24'h010101;
    cyc(1'b0, 1'b1);
    advN(7);
    chk("e111_done", 64'(done), 64'h1);
    advN(1);
`ifdef LOOP_NEST_COUNTER_AUTOWRAP_EN
    chk("e111_cnts", 64'(cnts), 64'h0);
    chk("e111_wrap", 64'(wrap), 64'h7);
    chk("e111_done8", 64'(done), 64'h0);
`else
    chk("e111_cnts", 64'(cnts), 64'h010101);
    chk("e111_wrap", 64'(wrap), 64'h0);
    chk("e111_done8", 64'(done), 64'h1);
`endif
    cyc(1'b0, 1'b0);

    // single dimension, 4-bit, end 15
    end1 = 4'hf;
    clr1 = 1'b1;
    cyc(1'b0, 1'b0);
    clr1 = 1'b0;
    adv1 = 1'b1;
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0);
    chk("d1_done14", 64'(done1), 64'h0);
    chk("d1_cnt14",  64'(cnts1), 64'he);
    cyc(1'b0, 1'b0);
    chk("d1_done15", 64'(done1), 64'h1);
    chk("d1_cnt15",  64'(cnts1), 64'hf);
    chk("d1_wrap15", 64'(wrap1), 64'h0);
    adv1 = 1'b0;
    cyc(1'b0, 1'b0);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
